fadd_arbiter: RTL

- Shares one external fadd instance between N independent requesters (FPU issue ports, e.g. integer-core and vector lanes).
- Round-robin arbitration, registered operand issue, and a tag pipeline that tracks which requester owns each in-flight add.
- Returns each result to its owner with a one-cycle valid pulse.
- Each requester has at most one add outstanding.

---
 rtl/fadd_arbiter.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/fadd_arbiter.sv
// -----------------------------------------------------------------------------
// fadd_arbiter
//
// Shares one external floating-point adder between N requesters. A round-robin
// search picks one eligible requester per cycle, its operands are registered
// onto fa_x1/fa_x2, and a tag pipeline (LAT+1 stages) follows the add through
// the adder so the sampled fa_y can be returned to its owner as a one-cycle
// resp_valid pulse. Each requester may have only one add outstanding; busy
// marks the requesters whose add is still in flight.
//
// Build option:
//   FADD_ARB_SUB_EN - when defined, req_op[i]=1 flips the sign of x2 on issue
//                     so the shared adder computes x1 - x2. When undefined,
//                     req_op is ignored and no extra logic is built.
//
// Parameters:
//   N    number of requesters (2..8)
//   LAT  adder pipeline depth in cycles (0 = combinational adder)
//
// Ports:
//   clk         clock, all state on rising edge
//   rstn        asynchronous active-low reset
//   req_valid   [N]     request present, per requester
//   req_x1      [32*N]  operand 1, requester i in bits [32*i+31:32*i]
//   req_x2      [32*N]  operand 2, same packing
//   req_op      [N]     1 = subtract (FADD_ARB_SUB_EN builds only)
//   req_ready   [N]     one-hot grant, handshake on req_valid & req_ready
//   resp_valid  [N]     one-hot result pulse
//   resp_y      [32]    result, qualified by resp_valid, holds otherwise
//   fa_x1/fa_x2 [32]    operands to the adder
//   fa_y        [32]    result from the adder
//   busy        [N]     requester has an add in flight
// -----------------------------------------------------------------------------
module fadd_arbiter #(
    parameter int N   = 4,
    parameter int LAT = 0
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [N-1:0]    req_valid,
    input  logic [32*N-1:0] req_x1,
    input  logic [32*N-1:0] req_x2,
    input  logic [N-1:0]    req_op,
    output logic [N-1:0]    req_ready,
    output logic [N-1:0]    resp_valid,
    output logic [31:0]     resp_y,
    output logic [31:0]     fa_x1,
    output logic [31:0]     fa_x2,
    input  logic [31:0]     fa_y,
    output logic [N-1:0]    busy
);

    localparam int IDW = $clog2(N);
    // A single requester still needs a one-bit id to keep the vectors legal.
    localparam int TW  = (IDW > 0) ? IDW : 1;

    logic [31:0]   x1_arr_s [N];
    logic [31:0]   x2_arr_s [N];
    logic [N-1:0]  elig_s;
    logic [N-1:0]  grant_s;
    logic [N-1:0]  done_s;
    logic          hs_s;
    logic [TW-1:0] gidx_s;
    logic [TW-1:0] cand_s;
    logic [TW-1:0] rr_next_s;
    logic [31:0]   x2_sel_s;
    int            idx_s;

    logic [TW-1:0] rr_ptr_r;
    logic [N-1:0]  busy_r;
    logic [N-1:0]  resp_valid_r;
    logic [31:0]   resp_y_r;
    logic [31:0]   fa_x1_r;
    logic [31:0]   fa_x2_r;
    logic          tag_vld_r [0:LAT];
    logic [TW-1:0] tag_id_r  [0:LAT];

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign x1_arr_s[i] = req_x1[32*i +: 32];
        assign x2_arr_s[i] = req_x2[32*i +: 32];
    end

    assign elig_s = req_valid & ~busy_r;

    // Round-robin search from rr_ptr, wrapping modulo N; first eligible wins.
    always_comb begin
        grant_s = {N{1'b0}};
        gidx_s  = {TW{1'b0}};
        cand_s  = {TW{1'b0}};
        hs_s    = 1'b0;
        idx_s   = 0;
        for (int k = 0; k < N; k++) begin
            idx_s = int'(rr_ptr_r) + k;
            if (idx_s >= N) begin
                idx_s = idx_s - N;
            end else begin
                idx_s = idx_s;
            end
            cand_s = TW'(idx_s);
            if (!hs_s && elig_s[cand_s]) begin
                hs_s            = 1'b1;
                grant_s[cand_s] = 1'b1;
                gidx_s          = cand_s;
            end else begin
                hs_s = hs_s;
            end
        end
    end

    // Pointer moves to the requester just after the winner.
    always_comb begin
        rr_next_s = {TW{1'b0}};
        if (gidx_s == TW'(N - 1)) begin
            rr_next_s = {TW{1'b0}};
        end else begin
            rr_next_s = gidx_s + TW'(1);
        end
    end

    // One-hot owner of the add whose result is on fa_y this cycle.
    always_comb begin
        done_s = {N{1'b0}};
        if (tag_vld_r[LAT]) begin
            done_s[tag_id_r[LAT]] = 1'b1;
        end else begin
            done_s = {N{1'b0}};
        end
    end

`ifdef FADD_ARB_SUB_EN
    // Subtract is a sign flip of x2; the adder does the rest.
    assign x2_sel_s = {x2_arr_s[gidx_s][31] ^ req_op[gidx_s], x2_arr_s[gidx_s][30:0]};
`else
    assign x2_sel_s = x2_arr_s[gidx_s];
    logic unused_op_s;
    assign unused_op_s = ^req_op;
`endif

    // Operand issue registers and round-robin pointer, updated on handshake.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fa_x1_r  <= 32'h0000_0000;
            fa_x2_r  <= 32'h0000_0000;
            rr_ptr_r <= {TW{1'b0}};
        end else if (hs_s) begin
            fa_x1_r  <= x1_arr_s[gidx_s];
            fa_x2_r  <= x2_sel_s;
            rr_ptr_r <= rr_next_s;
        end
    end

    // Tag stage 0 records which requester issued this cycle, if any.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tag_vld_r[0] <= 1'b0;
            tag_id_r[0]  <= {TW{1'b0}};
        end else begin
            tag_vld_r[0] <= hs_s;
            tag_id_r[0]  <= gidx_s;
        end
    end

    for (genvar s = 1; s <= LAT; s++) begin : g_tag
        // Tag stage s follows the adder pipeline one cycle behind stage s-1.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                tag_vld_r[s] <= 1'b0;
                tag_id_r[s]  <= {TW{1'b0}};
            end else begin
                tag_vld_r[s] <= tag_vld_r[s-1];
                tag_id_r[s]  <= tag_id_r[s-1];
            end
        end
    end

    // Completion: sample fa_y, pulse the owner and release its busy flag.
    // Issue and completion never target the same requester in one edge,
    // since a busy requester cannot be granted.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            resp_valid_r <= {N{1'b0}};
            resp_y_r     <= 32'h0000_0000;
            busy_r       <= {N{1'b0}};
        end else begin
            resp_valid_r <= done_s;
            busy_r       <= (busy_r & ~done_s) | grant_s;
            if (tag_vld_r[LAT]) begin
                resp_y_r <= fa_y;
            end
        end
    end

    // No grant is offered while reset is asserted.
    assign req_ready  = grant_s & {N{rstn}};
    assign resp_valid = resp_valid_r;
    assign resp_y     = resp_y_r;
    assign fa_x1      = fa_x1_r;
    assign fa_x2      = fa_x2_r;
    assign busy       = busy_r;

endmodule
